// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: md_op codes and FSM states.
package mul_div_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] MdMulW  = 3'd0;
    localparam logic [2:0] MdMulH  = 3'd1;
    localparam logic [2:0] MdMulHu = 3'd2;
    localparam logic [2:0] MdRsvd  = 3'd3;
    localparam logic [2:0] MdDivW  = 3'd4;
    localparam logic [2:0] MdModW  = 3'd5;
    localparam logic [2:0] MdDivWu = 3'd6;
    localparam logic [2:0] MdModWu = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } md_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_div(input logic [2:0] op);
        return (op == MdDivW) || (op == MdModW);
    endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Radix-2 restoring divider on operand magnitudes; 32 iterations, results are unsigned
// magnitudes and sign correction is left to the caller.
module div_iter
    import mul_div_unit_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;

    logic [XLEN-1:0] w_dvd_mag;
    logic [XLEN-1:0] w_dvs_mag;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    assign w_dvd_mag = (i_signed && i_dividend[XLEN-1]) ? (~i_dividend + 32'd1) : i_dividend;
    assign w_dvs_mag = (i_signed && i_divisor[XLEN-1])  ? (~i_divisor + 32'd1)  : i_divisor;

    // The quotient register doubles as the dividend shift register.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fits  = ~w_diff[XLEN];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 6'd0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_kill) begin
            r_cnt <= 6'd0;
        end else if (i_start) begin
            r_cnt <= 6'd32;
            r_rem <= '0;
            r_quo <= w_dvd_mag;
            r_div <= w_dvs_mag;
        end else if (r_cnt != 6'd0) begin
            r_cnt <= r_cnt - 6'd1;
            r_rem <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_fits};
        end
    end

    assign o_busy      = (r_cnt != 6'd0);
    assign o_done      = (r_cnt == 6'd1);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit: 2-cycle multiplier inline, 33-cycle iterative divider,
// stalls the front of the pipeline while busy and pulses result_valid_out once.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic            cpu_clk,
    input  logic            cpu_rstn,
    input  logic            valid_in,
    input  logic            mulordiv_in,
    input  logic [2:0]      md_op_in,
    input  logic [XLEN-1:0] src_a_in,
    input  logic [XLEN-1:0] src_b_in,
    input  logic            cancel_in,
    output logic            suspend_out,
    output logic [XLEN-1:0] result_out,
    output logic            result_valid_out
);

    md_state_e       r_state;
    md_state_e       w_state_next;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_src_a;
    logic [XLEN-1:0] r_src_b;
    logic [63:0]     r_prod;
    logic [XLEN-1:0] r_result;

    logic            w_start;
    logic            w_div_start;
    logic            w_div_busy;
    logic            w_div_done;
    logic [XLEN-1:0] w_div_quo;
    logic [XLEN-1:0] w_div_rem;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic            w_mul_signed;
    logic [63:0]     w_mul_a;
    logic [63:0]     w_mul_b;
    logic [63:0]     w_prod;
    logic [XLEN-1:0] w_result;

    assign w_start     = (r_state == StIdle) && valid_in && mulordiv_in && !cancel_in;
    assign w_div_start = w_start && is_div_op(md_op_in);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (cancel_in) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        w_state_next = is_div_op(md_op_in) ? StDiv : StMul;
                    end
                end
                StMul:  w_state_next = StDone;
                StDiv: begin
                    if (w_div_done || !w_div_busy) begin
                        w_state_next = StDone;
                    end
                end
                StDone: w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_op     <= 3'd0;
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else begin
            if (w_start) begin
                r_op    <= md_op_in;
                r_src_a <= src_a_in;
                r_src_b <= src_b_in;
            end
            if ((r_state == StMul) && !cancel_in) begin
                r_prod <= w_prod;
            end
            if ((r_state == StDone) && !cancel_in) begin
                r_result <= w_result;
            end
        end
    end

    // Sign-extending to 64 bits lets one unsigned multiply serve both MULH variants.
    assign w_mul_signed = (r_op == MdMulH);
    assign w_mul_a      = {{32{w_mul_signed & r_src_a[XLEN-1]}}, r_src_a};
    assign w_mul_b      = {{32{w_mul_signed & r_src_b[XLEN-1]}}, r_src_b};
    assign w_prod       = w_mul_a * w_mul_b;

    div_iter u_div_iter (
        .i_clk       (cpu_clk),
        .i_rst_n     (cpu_rstn),
        .i_start     (w_div_start),
        .i_kill      (cancel_in),
        .i_signed    (is_signed_div(md_op_in)),
        .i_dividend  (src_a_in),
        .i_divisor   (src_b_in),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    always_comb begin
        w_quo_fix = w_div_quo;
        w_rem_fix = w_div_rem;
        if (r_src_b == '0) begin
            w_quo_fix = '1;
            w_rem_fix = r_src_a;
        end else if (is_signed_div(r_op)) begin
            if (r_src_a[XLEN-1] ^ r_src_b[XLEN-1]) begin
                w_quo_fix = 32'd0 - w_div_quo;
            end
            if (r_src_a[XLEN-1]) begin
                w_rem_fix = 32'd0 - w_div_rem;
            end
        end
    end

    always_comb begin
        w_result = r_prod[XLEN-1:0];
        case (r_op)
            MdMulW, MdRsvd:   w_result = r_prod[XLEN-1:0];
            MdMulH, MdMulHu:  w_result = r_prod[63:XLEN];
            MdDivW, MdDivWu:  w_result = w_quo_fix;
            MdModW, MdModWu:  w_result = w_rem_fix;
            default:          w_result = r_prod[XLEN-1:0];
        endcase
    end

    // Live value in DONE, captured copy afterwards so the output holds until the next op.
    assign result_out       = (r_state == StDone) ? w_result : r_result;
    assign result_valid_out = (r_state == StDone) && !cancel_in;
    assign suspend_out      = !cancel_in &&
                              (w_start || (r_state == StMul) || (r_state == StDiv));

endmodule
